// File: rtl/mat_result_streamer.sv
// Streams a captured N x N result matrix one element per beat over a valid/ready port.
// Define MAT_STREAM_COLMAJOR_EN for column-major order; the default is row-major.
module mat_result_streamer #(
    parameter int W = 16,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [W*N*N-1:0] i_C,
    input  logic             i_done,
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_row_end,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_overrun
);

    // state  | meaning
    // IDLE   | no matrix held, waiting for i_done
    // STREAM | presenting buffer element at idx, advancing on each beat

    localparam int NE = N * N;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W*NE-1:0] mat_buf;
    logic            beat;
    logic            at_last;
    logic            capture;
    int              idx_nxt;

    // Stream position -> flat element slot; (0,0) sits in the MSB element.
    function automatic logic [W-1:0] pick(input logic [W*NE-1:0] m, input int i);
        int pos;
`ifdef MAT_STREAM_COLMAJOR_EN
        pos = (i % N) * N + (i / N);
`else
        pos = i;
`endif
        return m[W*(NE-1-pos) +: W];
    endfunction

    function automatic logic is_row_end(input int i);
        return (i % N) == (N - 1);
    endfunction

    function automatic logic is_last(input int i);
        return i == (NE - 1);
    endfunction

    assign beat    = o_valid && i_ready;
    assign at_last = (int'(idx) == NE - 1);
    assign idx_nxt = int'(idx) + 1;
    assign capture = i_done && ((state == IDLE) || (beat && at_last));

    // Buffer is only ever read while STREAM, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            mat_buf <= i_C;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_row_end <= 1'b0;
            o_last    <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_done) begin
                        state     <= STREAM;
                        idx       <= '0;
                        o_valid   <= 1'b1;
                        o_busy    <= 1'b1;
                        o_data    <= pick(i_C, 0);
                        o_row_end <= is_row_end(0);
                        o_last    <= is_last(0);
                    end
                end
                STREAM: begin
                    // A done pulse is only accepted alongside the final beat.
                    if (i_done && !(beat && at_last)) begin
                        o_overrun <= 1'b1;
                    end
                    if (beat) begin
                        if (at_last && i_done) begin
                            idx       <= '0;
                            o_data    <= pick(i_C, 0);
                            o_row_end <= is_row_end(0);
                            o_last    <= is_last(0);
                        end else if (at_last) begin
                            state     <= IDLE;
                            idx       <= '0;
                            o_valid   <= 1'b0;
                            o_busy    <= 1'b0;
                            o_data    <= '0;
                            o_row_end <= 1'b0;
                            o_last    <= 1'b0;
                        end else begin
                            idx       <= IW'(idx_nxt);
                            o_data    <= pick(mat_buf, idx_nxt);
                            o_row_end <= is_row_end(idx_nxt);
                            o_last    <= is_last(idx_nxt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mat_result_streamer.md
MAT_RESULT_STREAMER -- requirements
Module: mat_result_streamer

Interface
REQ-001 SHALL have parameter W, default 16: element width in bits (fp16 bit pattern; never interpreted).
REQ-002 SHALL have parameter N, default 3: matrix dimension; N*N elements per matrix.
REQ-003 SHALL have port i_clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_C  input  W*N*N: flat result matrix from the control unit's o_C; element (r,c) at bits [W*(N*N-1-(r*N+c)) +: W], so (0,0) is the MSB element.
REQ-006 SHALL have port i_done  input  1: control unit completion pulse; i_C is valid in that cycle.
REQ-007 SHALL have port o_data  output  W: current streamed element.
REQ-008 SHALL have port o_valid  output  1: o_data holds a valid element.
REQ-009 SHALL have port i_ready  input  1: downstream accepts o_data when o_valid && i_ready (a "beat").
REQ-010 SHALL have port o_row_end  output  1: the current element is the last of its row (or column, see REQ-030).
REQ-011 SHALL have port o_last  output  1: the current element is the final element of the matrix.
REQ-012 SHALL have port o_busy  output  1: a captured matrix is not yet fully streamed.
REQ-013 SHALL have port o_overrun  output  1: sticky flag; an i_done arrived while busy and was dropped.

Function
REQ-014 SHALL have two states: IDLE and STREAM.
REQ-015 In IDLE, i_done=1 SHALL capture i_C into an internal N*N*W buffer, clear the element index to 0, and move to STREAM at the same edge.
REQ-016 Latency: i_done sampled at edge k SHALL give o_valid=1 with element 0 in the cycle after edge k.
REQ-017 In STREAM, o_valid SHALL be 1; o_data SHALL be the buffer element at the current index.
REQ-018 Each beat SHALL advance the index by 1; without a beat, o_data, o_row_end and o_last SHALL hold stable.
REQ-019 o_row_end SHALL be 1 when (index mod N) == N-1; o_last SHALL be 1 when index == N*N-1; both SHALL be 0 whenever o_valid=0.
REQ-020 A beat on the last element with i_done=0 SHALL return to IDLE, with o_valid=0 in the next cycle.
REQ-021 A beat on the last element with i_done=1 in the same cycle SHALL capture the new i_C, reset the index to 0 and stay in STREAM (no bubble, no overrun).
REQ-022 i_done=1 in STREAM without a final-element beat SHALL be ignored and SHALL set o_overrun=1; the buffer SHALL be unchanged.
REQ-023 o_busy SHALL be 1 exactly when the state is STREAM.
REQ-024 o_valid SHALL never deassert in STREAM before the final beat, regardless of i_ready.
REQ-025 The index counter SHALL be ceil(log2(N*N)) bits wide, with minimum width 1.

Reset
REQ-026 i_rst=1 SHALL asynchronously force the state to IDLE, the index to 0, o_valid=0, o_data=0, o_row_end=0, o_last=0, o_busy=0 and o_overrun=0.
REQ-027 Reset mid-stream SHALL abandon the current matrix; after release, the block SHALL wait for a new i_done.
REQ-028 The buffer contents need not be reset, but o_data SHALL read 0 whenever o_valid=0.

Configuration
REQ-029 The macro MAT_STREAM_COLMAJOR_EN SHALL select the streaming order.
REQ-030 With MAT_STREAM_COLMAJOR_EN defined, index i SHALL map to element (i mod N, i div N), i.e. column-major order, and o_row_end SHALL mark the end of each column. Without it, index i SHALL map to element (i div N, i mod N), i.e. row-major order.

Verification
REQ-031 Row-major, N=3, i_C = elements 1..9 (0x0001..0x0009) with (0,0)=1; pulse i_done; i_ready=1 -> o_data 1,2,...,9 on 9 consecutive cycles; o_row_end on 3,6,9; o_last on 9; o_valid=0 on the 10th cycle.
REQ-032 Backpressure: same matrix; i_ready toggles 1,0,1,0 -> each element held stable while i_ready=0; 9 beats total; element order unchanged.
REQ-033 Back-to-back: all elements 0x3C00, then a second i_done with all elements 0x4000 in the same cycle as the final beat -> 9×0x3C00 then 9×0x4000 with no o_valid gap; o_overrun stays 0.
REQ-034 Overrun: i_done pulse at the 4th element with i_ready=0 -> o_overrun=1 and stays 1; the remaining elements come from the first matrix.
REQ-035 Reset mid-stream: assert i_rst after 4 beats -> all outputs 0 immediately; after release, no o_valid until the next i_done; a new matrix streams from element 0.
REQ-036 With MAT_STREAM_COLMAJOR_EN defined, elements 1..9 -> o_data 1,4,7,2,5,8,3,6,9; o_row_end on 7, 8 and 9.
